// File: rtl/reverb_engine.sv
// Feedback comb reverb sequencer: y[n] = x[n] + ((ALPHA_NUM * y[n-K]) >>> 3), run in place on sample memory.
// Optional macro REVERB_SATURATE_EN clamps each output to [-64, 63]; without it the sum wraps to 7 bits.
module reverb_engine #(
  parameter int unsigned N_SAMPLES = 133405,
  parameter int unsigned OUT_BASE  = 133405,
  parameter int unsigned DELAY_K   = 2205,
  parameter int unsigned ALPHA_NUM = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [6:0]  mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] sample_idx,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_X = 3'd1,
    S_RD_Y = 3'd2,
    S_CALC = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [31:0]        LP_K     = 32'(DELAY_K);
  localparam logic [31:0]        LP_OUT   = 32'(OUT_BASE);
  localparam logic [31:0]        LP_LAST  = 32'(N_SAMPLES - 1);
  localparam logic signed [10:0] LP_ALPHA = 11'(ALPHA_NUM);

  state_t      r_state;
  logic [31:0] r_n;
  logic [31:0] r_addr;
  logic        r_we;
  logic [6:0]  r_wdata;
  logic        r_busy;
  logic        r_done;
  logic [6:0]  r_x;
  logic [6:0]  r_yd;
  logic        r_no_echo;

  logic signed [10:0] w_x_ext;
  logic signed [10:0] w_yd_ext;
  logic signed [10:0] w_prod;
  logic signed [10:0] w_sum;
  logic [6:0]         w_result;
  logic               w_unused;

  assign w_unused = &{1'b0, mem_rdata[31:7]};

  assign w_x_ext  = {{4{r_x[6]}}, r_x};
  assign w_yd_ext = {{4{r_yd[6]}}, r_yd};
  assign w_prod   = LP_ALPHA * w_yd_ext;
  assign w_sum    = w_x_ext + (w_prod >>> 3);

`ifdef REVERB_SATURATE_EN
  always_comb begin
    w_result = w_sum[6:0];
    if (w_sum > 11'sd63)
      w_result = 7'h3F;
    else if (w_sum < -11'sd64)
      w_result = 7'h40;
  end
`else
  assign w_result = w_sum[6:0];
`endif

  // Read data lands one edge after its address cycle, so each capture happens on the
  // edge that leaves the corresponding read state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_n       <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_x       <= '0;
      r_yd      <= '0;
      r_no_echo <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n     <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RD_X;
          end
        end
        S_RD_X: begin
          r_x       <= mem_rdata[6:0];
          r_no_echo <= (r_n < LP_K);
          r_addr    <= LP_OUT + r_n - LP_K;
          r_state   <= S_RD_Y;
        end
        S_RD_Y: begin
          r_yd    <= r_no_echo ? 7'd0 : mem_rdata[6:0];
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_wdata <= w_result;
          r_addr  <= LP_OUT + r_n;
          r_we    <= 1'b1;
          r_state <= S_WR;
        end
        S_WR: begin
          r_we <= 1'b0;
          if (r_n == LP_LAST) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_n     <= r_n + 32'd1;
            r_addr  <= r_n + 32'd1;
            r_state <= S_RD_X;
          end
        end
        S_DONE: begin
          if (start) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_n     <= '0;
            r_addr  <= '0;
            r_state <= S_RD_X;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign mem_addr    = r_addr;
  assign mem_we      = r_we;
  assign mem_wdata   = r_wdata;
  assign sample_idx  = r_n;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_reverb_engine.sv
// Directed bench for reverb_engine: four instances with small parameter sets share one
// clock and reset, each backed by its own negedge-timed sample memory model.
module tb_reverb_engine;

  localparam int OB = 16;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD_Y = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd4;
  localparam logic [6:0] SENT    = 7'h2A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_v [4];
  logic        busy_v  [4];
  logic        done_v  [4];
  logic [31:0] addr_v  [4];
  logic        we_v    [4];
  logic [6:0]  wdata_v [4];
  logic [31:0] rdata_v [4];
  logic [31:0] idx_v   [4];
  logic [2:0]  dbg_v   [4];

  bit [6:0] mem [4][64];
  int       wr_cnt [4];
  bit       pl_en = 1'b0;
  int       pl_inst = 0;
  int       pl_addr = 0;
  bit [6:0] pl_data = '0;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reverb_engine #(.N_SAMPLES(4),  .OUT_BASE(OB), .DELAY_K(2),  .ALPHA_NUM(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .mem_addr(addr_v[0]), .mem_we(we_v[0]), .mem_wdata(wdata_v[0]), .mem_rdata(rdata_v[0]),
    .sample_idx(idx_v[0]), .o_dbg_state(dbg_v[0]));
  reverb_engine #(.N_SAMPLES(2),  .OUT_BASE(OB), .DELAY_K(1),  .ALPHA_NUM(7)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .mem_addr(addr_v[1]), .mem_we(we_v[1]), .mem_wdata(wdata_v[1]), .mem_rdata(rdata_v[1]),
    .sample_idx(idx_v[1]), .o_dbg_state(dbg_v[1]));
  reverb_engine #(.N_SAMPLES(2),  .OUT_BASE(OB), .DELAY_K(1),  .ALPHA_NUM(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .mem_addr(addr_v[2]), .mem_we(we_v[2]), .mem_wdata(wdata_v[2]), .mem_rdata(rdata_v[2]),
    .sample_idx(idx_v[2]), .o_dbg_state(dbg_v[2]));
  reverb_engine #(.N_SAMPLES(12), .OUT_BASE(OB), .DELAY_K(12), .ALPHA_NUM(5)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .busy(busy_v[3]), .done(done_v[3]),
    .mem_addr(addr_v[3]), .mem_we(we_v[3]), .mem_wdata(wdata_v[3]), .mem_rdata(rdata_v[3]),
    .sample_idx(idx_v[3]), .o_dbg_state(dbg_v[3]));

  // Memory model: read and write both happen on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_v[i]) begin
        mem[i][addr_v[i][5:0]] <= wdata_v[i];
        wr_cnt[i] <= wr_cnt[i] + 1;
      end
      rdata_v[i] <= {{25{mem[i][addr_v[i][5:0]][6]}}, mem[i][addr_v[i][5:0]]};
    end
    if (pl_en)
      mem[pl_inst][pl_addr[5:0]] <= pl_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int inst, input int a, input logic [6:0] d);
    pl_inst = inst;
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clk);
    #1;
    pl_en   = 1'b0;
  endtask

  // Starts one run and waits for done; optionally re-pulses start while in RD_Y at glitch_n.
  task automatic run(input int inst, input int glitch_n, output int cycles, output int viol);
    int prev;
    bit pulsed;
    cycles = 0;
    viol   = 0;
    prev   = 0;
    pulsed = 1'b0;
    start_v[inst] = 1'b1;
    do begin
      tick();
      cycles++;
      start_v[inst] = 1'b0;
      if (cycles == 1) begin
        check("busy_after_start", {31'b0, busy_v[inst]}, 32'd1);
        check("done_clear_after_start", {31'b0, done_v[inst]}, 32'd0);
      end
      if (idx_v[inst] < prev || idx_v[inst] > prev + 1) viol++;
      prev = idx_v[inst];
      if (glitch_n >= 0 && !pulsed && dbg_v[inst] == ST_RD_Y && idx_v[inst] == glitch_n) begin
        start_v[inst] = 1'b1;
        pulsed = 1'b1;
      end
    end while (!done_v[inst] && cycles < 200);
    check("done_seen", {31'b0, done_v[inst]}, 32'd1);
    check("busy_low_in_done", {31'b0, busy_v[inst]}, 32'd0);
  endtask

  logic [6:0] exp_a [4];
  logic [6:0] exp_b [2];
  logic [6:0] exp_c [2];
  logic [6:0] x_d   [12];
  int         cyc;
  int         viol;
  int         wr_base;

  initial begin
    for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
    exp_a = '{7'd10, 7'd20, 7'h7D, 7'd13};
`ifdef REVERB_SATURATE_EN
    exp_b = '{7'd63, 7'd63};
`else
    exp_b = '{7'd63, 7'h76};
`endif
    exp_c = '{7'h40, 7'h78};
    for (int i = 0; i < 12; i++) x_d[i] = 7'(i * 7 - 40);

    load(0, 0, 7'd10); load(0, 1, 7'd20); load(0, 2, 7'h78); load(0, 3, 7'd3);
    load(1, 0, 7'd63); load(1, 1, 7'd63);
    load(2, 0, 7'h40); load(2, 1, 7'd0);
    for (int i = 0; i < 12; i++) load(3, i, x_d[i]);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 12; j++) load(i, OB + j, SENT);

    tick();
    check("rst_busy", {31'b0, busy_v[0]}, 32'd0);
    check("rst_done", {31'b0, done_v[0]}, 32'd0);
    check("rst_we", {31'b0, we_v[0]}, 32'd0);
    check("rst_addr", addr_v[0], 32'd0);
    check("rst_wdata", {25'b0, wdata_v[0]}, 32'd0);
    check("rst_idx", idx_v[0], 32'd0);
    check("rst_state", {29'b0, dbg_v[0]}, {29'b0, ST_IDLE});
    rst_n = 1'b1;
    tick();

    // Main vector, with a stray start in RD_Y at n=2.
    run(0, 2, cyc, viol);
    check("a_latency", cyc, 32'd17);
    check("a_idx_monotonic", viol, 32'd0);
    check("a_write_count", wr_cnt[0], 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("a_y%0d", i), {25'b0, mem[0][OB + i]}, {25'b0, exp_a[i]});

    // Back-to-back run from DONE.
    for (int i = 0; i < 4; i++) load(0, OB + i, SENT);
    run(0, -1, cyc, viol);
    check("a2_latency", cyc, 32'd17);
    check("a2_write_count", wr_cnt[0], 32'd8);
    for (int i = 0; i < 4; i++) check($sformatf("a2_y%0d", i), {25'b0, mem[0][OB + i]}, {25'b0, exp_a[i]});

    run(1, -1, cyc, viol);
    check("b_latency", cyc, 32'd9);
    for (int i = 0; i < 2; i++) check($sformatf("b_y%0d", i), {25'b0, mem[1][OB + i]}, {25'b0, exp_b[i]});

    run(2, -1, cyc, viol);
    for (int i = 0; i < 2; i++) check($sformatf("c_y%0d", i), {25'b0, mem[2][OB + i]}, {25'b0, exp_c[i]});

    // Reset in the middle of the WR cycle for n=10.
    start_v[3] = 1'b1;
    tick();
    start_v[3] = 1'b0;
    cyc = 0;
    while (!(dbg_v[3] == ST_WR && idx_v[3] == 32'd10) && cyc < 200) begin
      tick();
      cyc++;
    end
    check("d_reached_wr10", {29'b0, dbg_v[3]}, {29'b0, ST_WR});
    rst_n = 1'b0;
    #1;
    check("d_rst_we", {31'b0, we_v[3]}, 32'd0);
    check("d_rst_busy", {31'b0, busy_v[3]}, 32'd0);
    check("d_rst_done", {31'b0, done_v[3]}, 32'd0);
    check("d_rst_state", {29'b0, dbg_v[3]}, {29'b0, ST_IDLE});
    check("d_rst_idx", idx_v[3], 32'd0);
    tick();
    tick();
    check("d_no_write_10", {25'b0, mem[3][OB + 10]}, {25'b0, SENT});
    check("d_partial_count", wr_cnt[3], 32'd10);
    for (int i = 0; i < 10; i++) check($sformatf("d_part_y%0d", i), {25'b0, mem[3][OB + i]}, {25'b0, x_d[i]});
    rst_n = 1'b1;
    tick();

    // K equal to N: output is a straight copy of the input.
    wr_base = wr_cnt[3];
    run(3, -1, cyc, viol);
    check("d_latency", cyc, 32'd49);
    check("d_write_count", wr_cnt[3] - wr_base, 32'd12);
    for (int i = 0; i < 12; i++) check($sformatf("d_y%0d", i), {25'b0, mem[3][OB + i]}, {25'b0, x_d[i]});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/reverb_engine.md
Name: reverb_engine

Overview:
- Sequencer and arithmetic stage that sits directly upstream of the sample data memory: it is the block driving that memory's address, write-enable and 7-bit write-data ports, and it consumes the memory's 32-bit sign-extended read data.
- Runs a feedback comb reverb in place: y[n] = x[n] + ((ALPHA_NUM * y[n-K]) >>> 3).
- Input samples x occupy addresses 0..N_SAMPLES-1; output samples y are written to OUT_BASE..OUT_BASE+N_SAMPLES-1.

Parameters:
- N_SAMPLES, 133405, number of input samples to process.
- OUT_BASE, 133405, first memory address of the output region.
- DELAY_K, 2205, echo delay in samples; legal range 1..N_SAMPLES.
- ALPHA_NUM, 5, feedback gain numerator over 8; legal range 0..7.

Ports:
- clk  in  1  system clock; memory reads and writes occur on its falling edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse in IDLE or DONE begins a run; ignored while busy.
- busy  out  1  high from the cycle after start until the final write.
- done  out  1  high in DONE; held until the next start or reset.
- mem_addr  out  32  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  7  signed sample to write.
- mem_rdata  in  32  sign-extended memory read data.
- sample_idx  out  32  current n, for debug and progress display.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - busy, done, mem_we, mem_addr, mem_wdata and sample_idx all go to 0.
  - Internal registers x_r and yd_r clear to 0.
- Memory timing:
  - An address driven after posedge t is read at the following negedge.
  - mem_rdata is therefore valid at posedge t+1, giving one cycle of read latency.
  - A write happens at the negedge of any cycle in which mem_we=1.
- State machine (all transitions on posedge clk):
  - IDLE: on start=1, set n=0, busy=1, go to RD_X.
  - RD_X: mem_addr=n, mem_we=0. Go to RD_Y.
  - RD_Y: capture x_r = mem_rdata[6:0].
    - If n>=DELAY_K: mem_addr=OUT_BASE+n-DELAY_K.
    - If n<DELAY_K: mem_addr is don't-care and a flag forces y[n-K]=0.
    - Go to CALC.
  - CALC: capture yd_r = mem_rdata[6:0], or 0 when the flag is set.
    - Compute the sum in 11-bit signed arithmetic: s = x_r + ((ALPHA_NUM * yd_r) >>> 3).
    - The shift is an arithmetic right shift, which truncates toward negative infinity.
    - Register the 7-bit result per the SATURATE_EN rules.
    - Go to WR.
  - WR: mem_addr=OUT_BASE+n, mem_we=1, mem_wdata=result.
    - If n==N_SAMPLES-1, go to DONE.
    - Otherwise n++, then go to RD_X.
  - DONE: busy=0, done=1, mem_we=0. On start=1, clear done, set n=0, go to RD_X.
- mem_we is asserted only in WR, exactly once per sample.
- Latency: 4 cycles per sample; first start to done = 4*N_SAMPLES+1 cycles.
- sample_idx equals n in every state; it is 0 in IDLE.
- start while busy=1: ignored, with no restart and no glitch on mem_we.
- Reset mid-run: abort immediately with no further writes. Partial output remains in memory.
- DELAY_K=N_SAMPLES: every sample takes the n<K path, so y=x.
- Address arithmetic is 32-bit unsigned; OUT_BASE+N_SAMPLES must not exceed the memory depth (a parameter-check responsibility, no runtime check).

Optional Feature:
- Macro: REVERB_SATURATE_EN.
- Defined: s is clamped to [-64, 63] before the write.
- Undefined: s is truncated to s[6:0], i.e. two's-complement wrap.

Test Plan:
- Reset mid-WR at n=10 → mem_we drops immediately, no write to OUT_BASE+10, busy=0, done=0, state IDLE.
- N=4, K=2, ALPHA_NUM=4, x={10,20,-8,3} → y={10,20,-3,13}; done rises exactly 17 cycles after start.
- K=1, ALPHA_NUM=7, x all 63 → with REVERB_SATURATE_EN, y[1]=63. Without it, y[1]=(63+55) wrapped = -10.
- Negative feedback: K=1, ALPHA_NUM=1, x={-64,0} → y[1] = (-64)>>>3 = -8.
- start pulsed during RD_Y at n=2 → ignored; exactly N write strobes total; sample_idx increments monotonically.
- Back-to-back runs: start in DONE → done clears next cycle, the second run rewrites an identical output region, mem_we count = 2N.
